wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DW, default 32, register and datapath width.
REQ-002 SHALL have parameter NREG, default 32, number of architectural registers; index width is log2(NREG)=5.
REQ-003 SHALL have a single clock and a synchronous, active-high reset:
  clk  in  1  sole clock, rising edge.
  rst  in  1  synchronous active-high reset.
REQ-004 SHALL have these remaining ports:
  valid_wb        in   1   MEM/WB holds a real instruction; 0 means bubble.
  RegWriteo_wb    in   1   instruction writes a register.
  MemtoRego_wb    in   1   1 selects load data, 0 selects ALU result.
  Jumpo_wb        in   1   jump instruction.
  opcodeo_wb      in   6   instruction opcode.
  rto_wb          in   5   rt field.
  rdo_wb          in   5   rd field.
  resulto_wb      in   DW  ALU result, or link address for jal.
  read_datao_wb   in   DW  data-memory load data.
  rs_addr_id      in   5   decode read port A address.
  rt_addr_id      in   5   decode read port B address.
  rs_data_id      out  DW  port A data.
  rt_data_id      out  DW  port B data.
  wb_we           out  1   registered: a write committed last cycle.
  wb_dest         out  5   registered: destination of that write.
  wb_data         out  DW  registered: value written.
  retired_count   out  32  count of retired valid instructions.

Function
REQ-005 SHALL select the destination as rdo_wb when opcodeo_wb=000000, 31 when Jumpo_wb=1 and opcodeo_wb=000011 (jal), and rto_wb otherwise.
REQ-006 SHALL select write data as read_datao_wb when MemtoRego_wb=1, else resulto_wb; for jal it SHALL be resulto_wb regardless of MemtoRego_wb.
REQ-007 SHALL commit the write on the rising clk edge iff valid_wb=1, RegWriteo_wb=1, destination!=0 and rst=0.
REQ-008 SHALL hold register 0 at 0; writes to it are dropped, and reads of address 0 return 0 on both ports.
REQ-009 SHALL make the read ports combinational (asynchronous) from the register array, with zero-cycle latency.
REQ-010 SHALL update wb_we, wb_dest and wb_data one cycle after a commit; wb_we SHALL be 0 in cycles with no commit, and wb_dest/wb_data SHALL then hold their last values.
REQ-011 SHALL increment retired_count on every edge with valid_wb=1 and rst=0, independent of RegWriteo_wb, and wrap from FFFFFFFF to 0.
REQ-012 SHALL serve a same-address simultaneous read and write on both ports identically, as defined in Configuration.
REQ-013 SHALL treat a bubble (valid_wb=0) as a no-op for every state element.

Reset
REQ-014 SHALL, while rst=1 at a clk edge, clear all NREG registers, retired_count, wb_we, wb_dest and wb_data to 0.
REQ-015 SHALL discard any write present in a reset cycle, even if valid_wb=1 and RegWriteo_wb=1.
REQ-016 SHALL have no asynchronous reset path.

Configuration
REQ-017 SHALL support macro WB_BYPASS_EN. When defined, a read address equal to a committing nonzero destination SHALL return the new write data in the same cycle. When undefined, that read SHALL return the old register value, and the downstream forwarding unit covers the hazard.

Structure
REQ-018 SHALL place the opcode constants OP_RTYPE=000000 and OP_JAL=000011, the link register index 31, and the DW default in the shared pipeline package.
REQ-019 SHALL contain one sub-module, wb_dest_sel, a combinational decoder implementing REQ-005/006 that outputs destination, data and write-enable.

Verification
REQ-020 Reset: preload r5=0x1234, assert rst for 1 cycle with a valid write to r6 present -> r5=0, r6=0, retired_count=0, wb_we=0.
REQ-021 R-type: opcode 000000, rd=8, rt=3, RegWrite=1, MemtoReg=0, result=0xDEADBEEF -> r8=0xDEADBEEF, r3 unchanged, next cycle wb_we=1, wb_dest=8.
REQ-022 Load and r0: opcode 100011, rt=0 then rt=9, read_data=0xCAFE0001 -> r0 stays 0 (wb_we=0), then r9=0xCAFE0001.
REQ-023 jal: Jumpo_wb=1, opcode 000011, result=0x00400010, MemtoReg=1 -> r31=0x00400010.
REQ-024 Same-cycle read/write on r10 with old value 1 and new value 2 -> rs_data_id=2 with WB_BYPASS_EN defined, 1 without; 2 on the next cycle in both builds.
REQ-025 Counter: 5 valid cycles interleaved with 3 bubbles -> retired_count=5; with preload FFFFFFFF, one valid cycle -> 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline constants for the write-back stage: opcodes, link register, default width.
package wb_regfile_pkg;

    localparam int          DW_DEFAULT = 32;
    localparam logic [5:0]  OP_RTYPE   = 6'b000000;
    localparam logic [5:0]  OP_JAL     = 6'b000011;
    localparam logic [4:0]  LINK_REG   = 5'd31;

endpackage

// File: rtl/wb_regfile_wb_dest_sel.sv
// Write-back decoder: picks destination register, write data and write-enable for the MEM/WB instruction.
module wb_dest_sel
    import wb_regfile_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          i_valid,
    input  logic          i_regwrite,
    input  logic          i_memtoreg,
    input  logic          i_jump,
    input  logic [5:0]    i_opcode,
    input  logic [4:0]    i_rt,
    input  logic [4:0]    i_rd,
    input  logic [DW-1:0] i_result,
    input  logic [DW-1:0] i_read_data,
    output logic [4:0]    o_dest,
    output logic [DW-1:0] o_data,
    output logic          o_we
);

    always_comb begin
        o_dest = i_rt;
        o_data = i_memtoreg ? i_read_data : i_result;
        if (i_opcode == OP_RTYPE) begin
            o_dest = i_rd;
        end else if (i_jump && (i_opcode == OP_JAL)) begin
            // jal writes the link address, never load data
            o_dest = LINK_REG;
            o_data = i_result;
        end
    end

    assign o_we = i_valid & i_regwrite & (o_dest != 5'd0);

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage register file with two async read ports and a retired-instruction counter.
// Optional WB_BYPASS_EN: a read of the committing destination returns the new data in the same cycle.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_wb,
    input  logic          RegWriteo_wb,
    input  logic          MemtoRego_wb,
    input  logic          Jumpo_wb,
    input  logic [5:0]    opcodeo_wb,
    input  logic [4:0]    rto_wb,
    input  logic [4:0]    rdo_wb,
    input  logic [DW-1:0] resulto_wb,
    input  logic [DW-1:0] read_datao_wb,
    input  logic [4:0]    rs_addr_id,
    input  logic [4:0]    rt_addr_id,
    output logic [DW-1:0] rs_data_id,
    output logic [DW-1:0] rt_data_id,
    output logic          wb_we,
    output logic [4:0]    wb_dest,
    output logic [DW-1:0] wb_data,
    output logic [31:0]   retired_count
);

    logic [DW-1:0] r_regs [NREG];
    logic          r_wb_we;
    logic [4:0]    r_wb_dest;
    logic [DW-1:0] r_wb_data;
    logic [31:0]   r_retired_count;

    logic [4:0]    w_dest;
    logic [DW-1:0] w_data;
    logic          w_we;
    logic [DW-1:0] w_rs_data;
    logic [DW-1:0] w_rt_data;

    wb_dest_sel #(.DW(DW)) u_dest_sel (
        .i_valid     (valid_wb),
        .i_regwrite  (RegWriteo_wb),
        .i_memtoreg  (MemtoRego_wb),
        .i_jump      (Jumpo_wb),
        .i_opcode    (opcodeo_wb),
        .i_rt        (rto_wb),
        .i_rd        (rdo_wb),
        .i_result    (resulto_wb),
        .i_read_data (read_datao_wb),
        .o_dest      (w_dest),
        .o_data      (w_data),
        .o_we        (w_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_wb_we         <= 1'b0;
            r_wb_dest       <= '0;
            r_wb_data       <= '0;
            r_retired_count <= '0;
        end else begin
            r_wb_we <= w_we;
            // w_we already excludes r0, so r_regs[0] is never written
            if (w_we) begin
                r_regs[w_dest] <= w_data;
                r_wb_dest      <= w_dest;
                r_wb_data      <= w_data;
            end
            if (valid_wb) r_retired_count <= r_retired_count + 32'd1;
        end
    end

    always_comb begin
        w_rs_data = (rs_addr_id == 5'd0) ? '0 : r_regs[rs_addr_id];
        w_rt_data = (rt_addr_id == 5'd0) ? '0 : r_regs[rt_addr_id];
`ifdef WB_BYPASS_EN
        if (w_we && (rs_addr_id == w_dest)) w_rs_data = w_data;
        if (w_we && (rt_addr_id == w_dest)) w_rt_data = w_data;
`else
        // no bypass: downstream forwarding covers the same-cycle hazard
`endif
    end

    assign rs_data_id    = w_rs_data;
    assign rt_data_id    = w_rt_data;
    assign wb_we         = r_wb_we;
    assign wb_dest       = r_wb_dest;
    assign wb_data       = r_wb_data;
    assign retired_count = r_retired_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_wb;
    logic          RegWriteo_wb;
    logic          MemtoRego_wb;
    logic          Jumpo_wb;
    logic [5:0]    opcodeo_wb;
    logic [4:0]    rto_wb;
    logic [4:0]    rdo_wb;
    logic [DW-1:0] resulto_wb;
    logic [DW-1:0] read_datao_wb;
    logic [4:0]    rs_addr_id;
    logic [4:0]    rt_addr_id;
    logic [DW-1:0] rs_data_id;
    logic [DW-1:0] rt_data_id;
    logic          wb_we;
    logic [4:0]    wb_dest;
    logic [DW-1:0] wb_data;
    logic [31:0]   retired_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] bypass_exp;

    always #5 clk = ~clk;

    wb_regfile #(.DW(DW), .NREG(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_wb      (valid_wb),
        .RegWriteo_wb  (RegWriteo_wb),
        .MemtoRego_wb  (MemtoRego_wb),
        .Jumpo_wb      (Jumpo_wb),
        .opcodeo_wb    (opcodeo_wb),
        .rto_wb        (rto_wb),
        .rdo_wb        (rdo_wb),
        .resulto_wb    (resulto_wb),
        .read_datao_wb (read_datao_wb),
        .rs_addr_id    (rs_addr_id),
        .rt_addr_id    (rt_addr_id),
        .rs_data_id    (rs_data_id),
        .rt_data_id    (rt_data_id),
        .wb_we         (wb_we),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .retired_count (retired_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic j,
                         input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] res, input logic [31:0] rdat);
        valid_wb      = v;
        RegWriteo_wb  = rw;
        MemtoRego_wb  = m2r;
        Jumpo_wb      = j;
        opcodeo_wb    = op;
        rto_wb        = rt;
        rdo_wb        = rd;
        resulto_wb    = res;
        read_datao_wb = rdat;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rs_addr_id = a;
        rt_addr_id = a;
        #1;
        chk({tag, "_rs"}, rs_data_id, exp);
        chk({tag, "_rt"}, rt_data_id, exp);
    endtask

    initial begin
        rst = 1'b1;
        rs_addr_id = '0;
        rt_addr_id = '0;
        bubble();
        tick();
        tick();
        rst = 1'b0;
        chk("rst_retired", retired_count, 32'd0);
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_dest", {27'd0, wb_dest}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rd_check("rst_r1", 5'd1, 32'd0);

        // preload r5, then reset with a write to r6 pending
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'd0, 5'd5, 32'h1234, 32'd0);
        tick();
        bubble();
        rd_check("pre_r5", 5'd5, 32'h1234);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'd0, 5'd6, 32'h55, 32'd0);
        tick();
        rst = 1'b0;
        bubble();
        rd_check("rst_r5", 5'd5, 32'd0);
        rd_check("rst_r6", 5'd6, 32'd0);
        chk("rst2_retired", retired_count, 32'd0);
        chk("rst2_wb_we", {31'd0, wb_we}, 32'd0);

        // R-type to rd=8; rt=3 must stay untouched
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'd3, 5'd8, 32'hDEADBEEF, 32'h0BAD0BAD);
        tick();
        bubble();
        rd_check("rtype_r8", 5'd8, 32'hDEADBEEF);
        rd_check("rtype_r3", 5'd3, 32'd0);
        chk("rtype_wb_we", {31'd0, wb_we}, 32'd1);
        chk("rtype_wb_dest", {27'd0, wb_dest}, 32'd8);
        chk("rtype_wb_data", wb_data, 32'hDEADBEEF);
        tick();
        chk("idle_wb_we", {31'd0, wb_we}, 32'd0);
        chk("idle_wb_dest_hold", {27'd0, wb_dest}, 32'd8);
        chk("idle_wb_data_hold", wb_data, 32'hDEADBEEF);

        // load to r0 is dropped, then load to r9
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'b100011, 5'd0, 5'd7, 32'h111, 32'hCAFE0001);
        tick();
        chk("ld_r0_wb_we", {31'd0, wb_we}, 32'd0);
        rd_check("ld_r0", 5'd0, 32'd0);
        rd_check("ld_r7", 5'd7, 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'b100011, 5'd9, 5'd7, 32'h111, 32'hCAFE0001);
        tick();
        bubble();
        rd_check("ld_r9", 5'd9, 32'hCAFE0001);
        chk("ld_wb_dest", {27'd0, wb_dest}, 32'd9);

        // jal with MemtoReg=1 still writes the link address to r31
        drive(1'b1, 1'b1, 1'b1, 1'b1, 6'b000011, 5'd4, 5'd5, 32'h00400010, 32'hBAD);
        tick();
        bubble();
        rd_check("jal_r31", 5'd31, 32'h00400010);
        rd_check("jal_r4", 5'd4, 32'd0);
        chk("jal_wb_dest", {27'd0, wb_dest}, 32'd31);

        // same-cycle read/write on r10
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'd0, 5'd10, 32'd1, 32'd0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5'd0, 5'd10, 32'd2, 32'd0);
`ifdef WB_BYPASS_EN
        bypass_exp = 32'd2;
`else
        bypass_exp = 32'd1;
`endif
        rd_check("byp_same", 5'd10, bypass_exp);
        tick();
        bubble();
        rd_check("byp_next", 5'd10, 32'd2);

        // counter: 5 valid cycles, 3 bubbles carrying a would-be write to r12
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1 || i == 3 || i == 5)
                drive(1'b0, 1'b1, 1'b0, 1'b0, 6'b000000, 5'd0, 5'd12, 32'h77, 32'd0);
            else
                drive(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'd0, 5'd13, 32'h88, 32'd0);
            tick();
        end
        bubble();
        chk("cnt_5", retired_count, 32'd5);
        rd_check("bubble_r12", 5'd12, 32'd0);
        rd_check("norw_r13", 5'd13, 32'd0);

        // wrap from all-ones
        @(negedge clk);
        force dut.r_retired_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retired_count;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 5'd0, 5'd0, 32'd0, 32'd0);
        tick();
        bubble();
        chk("cnt_wrap", retired_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
